adc_frame_sequencer: RTL and testbench
======================================

Name: adc_frame_sequencer

Overview:
- Scans the image sensor pixel array in raster order, one pixel at a time.
- For each pixel it drives the sensor row/column select, waits for the analog settle time, and triggers one ADC conversion through the serial ADC driver (startCapture/cs/conversionComplete handshake).
- It writes the 8-bit result into the frame buffer write port.
- Sits between the software-facing frame control registers and the ADC driver; it is the only master of that driver.

Parameters:
- COLS, 112, pixels per row (1..256)
- ROWS, 112, rows per frame (1..256)
- ADC_RES, 8, sample width in bits
- SETTLE_TICKS, 4, clk cycles between select change and conversion start (1..255)
- TIMEOUT_TICKS, 64, max clk cycles spent in any ADC handshake wait before abort (2..255)
- ADDR_W, 14, frame buffer address width; must satisfy 2^ADDR_W >= ROWS*COLS

Ports:
- clk  in  1  system clock (20 MHz)
- reset  in  1  asynchronous, active-high reset
- frameStart  in  1  one-cycle pulse; begins a frame if idle, ignored otherwise
- frameAbort  in  1  level; ends the current frame at the next pixel boundary
- busy  out  1  high from accepted frameStart until frameDone
- frameDone  out  1  one-cycle pulse at end of frame (normal or aborted)
- frameErr  out  1  sticky; set on handshake timeout, cleared by next accepted frameStart
- rowSel  out  8  sensor row select
- colSel  out  8  sensor column select
- adcStart_n  out  1  to ADC driver startCapture, active low
- adcCs  in  1  ADC driver cs (low = conversion in progress)
- adcDone_n  in  1  ADC driver conversionComplete, active low
- adcData  in  ADC_RES  ADC driver dataout
- pixWe  out  1  frame buffer write enable, one cycle per pixel
- pixAddr  out  ADDR_W  row*COLS+col, running counter
- pixData  out  ADC_RES  sample written

Behaviour:
- Reset (async, active-high): state IDLE; busy=0, frameDone=0, frameErr=0, adcStart_n=1, pixWe=0, rowSel=0, colSel=0, pixAddr=0, pixData=0.
- IDLE:
  - On frameStart: row=col=0, pixAddr=0, frameErr=0, busy=1, settle counter=SETTLE_TICKS, go to SETTLE.
- SETTLE:
  - Decrement the counter each cycle.
  - When it reaches 0: go to REQ, drive adcStart_n=0, load the timeout counter.
- REQ:
  - Hold adcStart_n=0 until adcCs==0 is sampled. The driver only accepts after its quiet time, so the wait is variable.
  - Then set adcStart_n=1 and go to CONV.
- CONV:
  - Wait for adcDone_n==0.
  - Then register pixData=adcData and pulse pixWe=1 for exactly one cycle, with the current pixAddr. Go to WAIT_IDLE.
- WAIT_IDLE:
  - Wait for adcCs==1, then go to NEXT. This prevents stale adcDone_n from being counted as a new conversion.
- NEXT:
  - If frameAbort, or (row==ROWS-1 and col==COLS-1): pulse frameDone, busy=0, go to IDLE.
  - Otherwise advance: col+1; at col==COLS-1, col=0 and row+1. pixAddr+1.
  - Reload settle counter and go to SETTLE.
- Timeout:
  - REQ, CONV and WAIT_IDLE each reload a counter on entry.
  - If it reaches 0: set frameErr, adcStart_n=1, no pixWe, pulse frameDone, busy=0, go to IDLE.
- Latency and handshake rules:
  - Minimum pixel period is SETTLE_TICKS + ADC driver latency + 2 cycles.
  - pixWe never asserts twice for one pixAddr.
  - rowSel/colSel change only in NEXT, never while adcCs==0.
- Simultaneous events:
  - frameStart while busy: ignored.
  - frameStart in the same cycle as frameDone: ignored; IDLE is entered next cycle.
  - frameAbort only takes effect in NEXT, so the in-flight pixel is always written.
- Reset mid-conversion: immediate IDLE, adcStart_n=1. The ADC driver finishes on its own; the next frame's REQ waits for it to become ready.

Decomposition:
- Shared package: state encoding (IDLE, SETTLE, REQ, CONV, WAIT_IDLE, NEXT), ADC_RES, and the active-low polarity constants for startCapture/conversionComplete, shared with the ADC driver.
- One natural sub-module: pixel_scan_counter (row/col/pixAddr raster counter with wrap and last-pixel flag).

Test Plan:
- ROWS=2, COLS=3, bench ADC model returns 0x10+index -> six pixWe pulses, addrs 0..5, data 0x10..0x15, one frameDone, busy low afterwards, frameErr=0.
- ADC model delays cs-low by 7 cycles after start -> adcStart_n held low exactly until adcCs falls; no duplicate writes.
- ADC model never asserts adcDone_n, TIMEOUT_TICKS=16 -> frameErr=1 and frameDone 16 cycles after CONV entry, no pixWe; next frameStart clears frameErr.
- frameAbort asserted during pixel 2 conversion -> pixel 2 written, frameDone next, total 3 writes.
- Async reset mid-CONV -> all outputs at reset values immediately; following frameStart completes a full frame correctly.
- frameStart pulsed while busy and coincident with frameDone -> ignored, pixAddr sequence unaffected.

Source files
------------

// File: rtl/adc_frame_sequencer_pkg.sv
// Shared definitions for the ADC frame sequencer and the serial ADC driver.
// Holds the sequencer state encoding, the default sample width and the
// active-low polarity of the startCapture / conversionComplete strobes.
package adc_frame_sequencer_pkg;

  localparam int ADC_RES_DEFAULT = 8;

  // startCapture and conversionComplete are both active low on the driver.
  localparam logic START_ACTIVE = 1'b0;
  localparam logic START_IDLE   = 1'b1;
  localparam logic DONE_ACTIVE  = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_REQ,
    ST_CONV,
    ST_WAIT_IDLE,
    ST_NEXT
  } seq_state_t;

endpackage

// File: rtl/adc_frame_sequencer_if.sv
// Bundle of every sequencer signal except clk/reset.
//   frame control : frameStart, frameAbort (to sequencer); busy, frameDone,
//                   frameErr (from sequencer)
//   sensor select : rowSel, colSel (from sequencer)
//   ADC driver    : adcStart_n (from sequencer); adcCs, adcDone_n, adcData
//   frame buffer  : pixWe, pixAddr, pixData (from sequencer)
// master = the sequencer, slave = its surroundings.
interface adc_frame_sequencer_if
  import adc_frame_sequencer_pkg::*;
#(
  parameter int ADC_RES = ADC_RES_DEFAULT,
  parameter int ADDR_W  = 14
);
  logic               frameStart;
  logic               frameAbort;
  logic               busy;
  logic               frameDone;
  logic               frameErr;
  logic [7:0]         rowSel;
  logic [7:0]         colSel;
  logic               adcStart_n;
  logic               adcCs;
  logic               adcDone_n;
  logic [ADC_RES-1:0] adcData;
  logic               pixWe;
  logic [ADDR_W-1:0]  pixAddr;
  logic [ADC_RES-1:0] pixData;

  modport master (
    input  frameStart, frameAbort, adcCs, adcDone_n, adcData,
    output busy, frameDone, frameErr, rowSel, colSel, adcStart_n,
           pixWe, pixAddr, pixData
  );

  modport slave (
    output frameStart, frameAbort, adcCs, adcDone_n, adcData,
    input  busy, frameDone, frameErr, rowSel, colSel, adcStart_n,
           pixWe, pixAddr, pixData
  );
endinterface

// File: rtl/adc_frame_sequencer_pixel_scan_counter.sv
// Raster position counter for the frame sequencer.
//   clk, reset : clock, asynchronous active-high reset
//   clr_i      : return to pixel (0,0), address 0
//   adv_i      : step to the next pixel in raster order
//   row_o/col_o: current row/column, addr_o: row*COLS+col kept as a counter
//   last_o     : current pixel is the final one of the frame
module adc_frame_sequencer_pixel_scan_counter #(
  parameter int ROWS   = 112,
  parameter int COLS   = 112,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              adv_i,
  output logic [7:0]        row_o,
  output logic [7:0]        col_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);
  localparam logic [7:0] ROW_LAST = 8'(ROWS - 1);
  localparam logic [7:0] COL_LAST = 8'(COLS - 1);

  logic [7:0]        row_q, row_d, col_q, col_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    addr_d = addr_q;
    if (clr_i) begin
      row_d  = '0;
      col_d  = '0;
      addr_d = '0;
    end else if (adv_i) begin
      // The address runs linearly, so no multiplier is needed for row*COLS.
      addr_d = addr_q + 1'b1;
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = row_q + 8'd1;
      end else begin
        col_d = col_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q  <= '0;
      col_q  <= '0;
      addr_q <= '0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      addr_q <= addr_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign addr_o = addr_q;
  assign last_o = (row_q == ROW_LAST) && (col_q == COL_LAST);

endmodule

// File: rtl/adc_frame_sequencer.sv
// Frame sequencer: scans the sensor in raster order, and for every pixel
// drives row/col select, waits the analog settle time, runs one conversion
// through the serial ADC driver and writes the sample to the frame buffer.
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : master side of adc_frame_sequencer_if (frame control, sensor
//           select, ADC driver handshake, frame buffer write port)
module adc_frame_sequencer
  import adc_frame_sequencer_pkg::*;
#(
  parameter int COLS          = 112,
  parameter int ROWS          = 112,
  parameter int ADC_RES       = ADC_RES_DEFAULT,
  parameter int SETTLE_TICKS  = 4,
  parameter int TIMEOUT_TICKS = 64,
  parameter int ADDR_W        = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  adc_frame_sequencer_if.master bus
);
  localparam logic [7:0] SETTLE_LD  = 8'(SETTLE_TICKS);
  localparam logic [7:0] TIMEOUT_LD = 8'(TIMEOUT_TICKS);

  seq_state_t         state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               start_n_q, start_n_d;
  logic               we_q, we_d;
  logic [ADC_RES-1:0] data_q, data_d;
  logic               scan_clr, scan_adv, scan_last, tmo_fire;
  logic [7:0]         row_w, col_w;
  logic [ADDR_W-1:0]  addr_w;

  adc_frame_sequencer_pixel_scan_counter #(
    .ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W)
  ) u_scan (
    .clk(clk), .reset(reset), .clr_i(scan_clr), .adv_i(scan_adv),
    .row_o(row_w), .col_o(col_w), .addr_o(addr_w), .last_o(scan_last)
  );

  // One counter serves both the settle delay and the handshake timeout;
  // each wait state reloads it on entry.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    start_n_d = start_n_q;
    we_d      = 1'b0;
    data_d    = data_q;
    scan_clr  = 1'b0;
    scan_adv  = 1'b0;
    tmo_fire  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A start coinciding with the frameDone pulse is dropped.
        if (bus.frameStart && !done_q) begin
          scan_clr = 1'b1;
          err_d    = 1'b0;
          busy_d   = 1'b1;
          cnt_d    = SETTLE_LD;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q <= 8'd1) begin
          start_n_d = START_ACTIVE;
          cnt_d     = TIMEOUT_LD;
          state_d   = ST_REQ;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_REQ: begin
        if (bus.adcCs == 1'b0) begin
          start_n_d = START_IDLE;
          cnt_d     = TIMEOUT_LD;
          state_d   = ST_CONV;
        end else begin
          cnt_d    = cnt_q - 8'd1;
          tmo_fire = (cnt_q <= 8'd1);
        end
      end
      ST_CONV: begin
        if (bus.adcDone_n == DONE_ACTIVE) begin
          data_d  = bus.adcData;
          we_d    = 1'b1;
          cnt_d   = TIMEOUT_LD;
          state_d = ST_WAIT_IDLE;
        end else begin
          cnt_d    = cnt_q - 8'd1;
          tmo_fire = (cnt_q <= 8'd1);
        end
      end
      ST_WAIT_IDLE: begin
        // Waiting for cs to rise keeps a lingering done strobe from being
        // taken as the next pixel's conversion.
        if (bus.adcCs == 1'b1) begin
          state_d = ST_NEXT;
        end else begin
          cnt_d    = cnt_q - 8'd1;
          tmo_fire = (cnt_q <= 8'd1);
        end
      end
      ST_NEXT: begin
        if (bus.frameAbort || scan_last) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          scan_adv = 1'b1;
          cnt_d    = SETTLE_LD;
          state_d  = ST_SETTLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (tmo_fire) begin
      err_d     = 1'b1;
      start_n_d = START_IDLE;
      we_d      = 1'b0;
      done_d    = 1'b1;
      busy_d    = 1'b0;
      state_d   = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      start_n_q <= START_IDLE;
      we_q      <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      start_n_q <= start_n_d;
      we_q      <= we_d;
      data_q    <= data_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.frameDone  = done_q;
  assign bus.frameErr   = err_q;
  assign bus.adcStart_n = start_n_q;
  assign bus.pixWe      = we_q;
  assign bus.pixData    = data_q;
  assign bus.rowSel     = row_w;
  assign bus.colSel     = col_w;
  assign bus.pixAddr    = addr_w;

endmodule

// File: tb/tb_adc_frame_sequencer.sv
// Directed bench for adc_frame_sequencer with a behavioural ADC driver model
// and a write scoreboard.
module tb_adc_frame_sequencer;
  localparam int ROWS = 2;
  localparam int COLS = 3;
  localparam int SETTLE = 4;
  localparam int TMO = 16;
  localparam int AW = 14;
  localparam int DW = 8;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  adc_frame_sequencer_if #(.ADC_RES(DW), .ADDR_W(AW)) bus ();

  adc_frame_sequencer #(
    .COLS(COLS), .ROWS(ROWS), .ADC_RES(DW), .SETTLE_TICKS(SETTLE),
    .TIMEOUT_TICKS(TMO), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  exp_t sb[$];

  int wr_cnt = 0, done_cnt = 0, cyc = 0;
  int conv_entry_cyc = 0, done_cyc = 0;
  int run_len = 0, runs = 0, run_sum = 0;

  int cs_delay = 1, conv_len = 2, m_phase = 0, m_cnt = 0, m_idx = 0;
  bit never_done = 1'b0, m_flush = 1'b0;
  logic [DW-1:0] m_base = 8'h10;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input int n, input logic [DW-1:0] base);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.addr = AW'(k);
      e.data = base + DW'(k);
      sb.push_back(e);
    end
  endtask

  task automatic start_frame();
    bus.frameStart = 1'b1;
    @(negedge clk);
    bus.frameStart = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (bus.frameDone !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 32'(bus.frameDone), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_frameDone"}, 32'(bus.frameDone), 32'd0);
    check({tag, "_frameErr"}, 32'(bus.frameErr), 32'd0);
    check({tag, "_adcStart_n"}, 32'(bus.adcStart_n), 32'd1);
    check({tag, "_pixWe"}, 32'(bus.pixWe), 32'd0);
    check({tag, "_rowSel"}, 32'(bus.rowSel), 32'd0);
    check({tag, "_colSel"}, 32'(bus.colSel), 32'd0);
    check({tag, "_pixAddr"}, 32'(bus.pixAddr), 32'd0);
    check({tag, "_pixData"}, 32'(bus.pixData), 32'd0);
  endtask

  // ADC driver model: cs falls cs_delay cycles after startCapture is seen,
  // done strobes conv_len cycles later and is held two cycles before cs rises.
  initial begin : adc_model
    bus.adcCs = 1'b1;
    bus.adcDone_n = 1'b1;
    bus.adcData = '0;
    forever begin
      @(negedge clk);
      if (m_flush) begin
        m_phase = 0; m_cnt = 0; m_flush = 1'b0;
        bus.adcCs = 1'b1; bus.adcDone_n = 1'b1;
      end else begin
        case (m_phase)
          0: if (bus.adcStart_n === 1'b0) begin
               m_cnt++;
               if (m_cnt >= cs_delay) begin bus.adcCs = 1'b0; m_phase = 1; m_cnt = 0; end
             end else m_cnt = 0;
          1: begin
               m_cnt++;
               if (!never_done && m_cnt >= conv_len) begin
                 bus.adcDone_n = 1'b0;
                 bus.adcData = m_base + DW'(m_idx);
                 m_idx++; m_phase = 2; m_cnt = 0;
               end
             end
          default: begin
               m_cnt++;
               if (m_cnt >= 2) begin
                 bus.adcDone_n = 1'b1; bus.adcCs = 1'b1; m_phase = 0; m_cnt = 0;
               end
             end
        endcase
      end
    end
  end

  // Output monitor: scoreboard pops on pixWe, handshake invariants.
  initial begin : monitor
    logic prev_start_n, prev_cs, prev_reset;
    logic [15:0] prev_sel;
    exp_t e;
    prev_start_n = 1'b1; prev_cs = 1'b1; prev_reset = 1'b1; prev_sel = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (reset === 1'b0 && prev_reset === 1'b0) begin
        if (bus.pixWe === 1'b1) begin
          wr_cnt++;
          if (sb.size() == 0) check("wr_unexpected", 32'(bus.pixWe), 32'd0);
          else begin
            e = sb.pop_front();
            check("wr_addr", 32'(bus.pixAddr), 32'(e.addr));
            check("wr_data", 32'(bus.pixData), 32'(e.data));
          end
        end
        if (bus.frameDone === 1'b1) begin done_cnt++; done_cyc = cyc; end
        if (prev_start_n === 1'b0 && bus.adcStart_n === 1'b1) begin
          conv_entry_cyc = cyc; runs++; run_sum += run_len; run_len = 0;
        end
        if (bus.adcStart_n === 1'b0) begin
          run_len++;
          check("start_low_while_cs_high", 32'(bus.adcCs), 32'd1);
        end
        if (prev_cs === 1'b0 && bus.adcCs === 1'b0)
          check("sel_stable_cs_low", 32'({bus.rowSel, bus.colSel}), 32'(prev_sel));
      end else begin
        run_len = 0;
      end
      prev_start_n = bus.adcStart_n;
      prev_cs = bus.adcCs;
      prev_reset = reset;
      prev_sel = {bus.rowSel, bus.colSel};
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : directed
    int n, wr0, dn0, r0, s0;
    bus.frameStart = 1'b0;
    bus.frameAbort = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Normal 2x3 frame
    m_base = 8'h10; m_idx = 0; cs_delay = 1; conv_len = 2;
    push_frame(6, 8'h10);
    wr0 = wr_cnt; dn0 = done_cnt;
    start_frame();
    check("t1_busy_after_start", 32'(bus.busy), 32'd1);
    wait_done("t1");
    check("t1_busy_low", 32'(bus.busy), 32'd0);
    check("t1_err", 32'(bus.frameErr), 32'd0);
    @(negedge clk);
    check("t1_done_one_cycle", 32'(bus.frameDone), 32'd0);
    check("t1_writes", 32'(wr_cnt - wr0), 32'd6);
    check("t1_dones", 32'(done_cnt - dn0), 32'd1);
    check("t1_sb_empty", 32'(sb.size()), 32'd0);

    // Slow driver accept: cs falls 7 cycles after start
    repeat (3) @(negedge clk);
    m_base = 8'h30; m_idx = 0; cs_delay = 7;
    push_frame(6, 8'h30);
    wr0 = wr_cnt; r0 = runs; s0 = run_sum;
    start_frame();
    wait_done("t2");
    check("t2_writes", 32'(wr_cnt - wr0), 32'd6);
    check("t2_start_runs", 32'(runs - r0), 32'd6);
    check("t2_start_low_total", 32'(run_sum - s0), 32'd42);
    check("t2_sb_empty", 32'(sb.size()), 32'd0);

    // Conversion never completes: timeout
    repeat (3) @(negedge clk);
    cs_delay = 1; never_done = 1'b1;
    wr0 = wr_cnt;
    start_frame();
    wait_done("t3");
    check("t3_done_after_conv_entry", 32'(done_cyc - conv_entry_cyc), 32'(TMO));
    check("t3_err_set", 32'(bus.frameErr), 32'd1);
    check("t3_busy_low", 32'(bus.busy), 32'd0);
    repeat (3) @(negedge clk);
    check("t3_err_sticky", 32'(bus.frameErr), 32'd1);
    check("t3_no_writes", 32'(wr_cnt - wr0), 32'd0);
    never_done = 1'b0; m_flush = 1'b1;
    repeat (3) @(negedge clk);

    // Abort during pixel 2 conversion
    m_base = 8'h20; m_idx = 0; conv_len = 2;
    push_frame(3, 8'h20);
    wr0 = wr_cnt; dn0 = done_cnt;
    start_frame();
    check("t4_err_cleared", 32'(bus.frameErr), 32'd0);
    n = 0;
    while (wr_cnt - wr0 < 2 && n < 300) begin @(negedge clk); n++; end
    while (bus.adcCs !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    while (bus.adcCs !== 1'b0 && n < 300) begin @(negedge clk); n++; end
    check("t4_reached_pix2", 32'(bus.adcCs), 32'd0);
    bus.frameAbort = 1'b1;
    wait_done("t4");
    bus.frameAbort = 1'b0;
    check("t4_writes", 32'(wr_cnt - wr0), 32'd3);
    check("t4_dones", 32'(done_cnt - dn0), 32'd1);
    check("t4_sb_empty", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);

    // Asynchronous reset during CONV, then a full frame
    m_base = 8'h40; m_idx = 0; conv_len = 6;
    start_frame();
    n = 0;
    while (!(bus.adcCs === 1'b0 && bus.adcStart_n === 1'b1 && bus.busy === 1'b1) && n < 300) begin
      @(negedge clk); n++;
    end
    check("t5_in_conv", 32'(bus.adcStart_n), 32'd1);
    reset = 1'b1;
    #1;
    check_reset_vals("t5_rst");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (!(m_phase == 0 && bus.adcCs === 1'b1) && n < 100) begin @(negedge clk); n++; end
    check("t5_adc_finished", 32'(bus.adcCs), 32'd1);
    conv_len = 2; m_idx = 0; m_base = 8'h50;
    push_frame(6, 8'h50);
    wr0 = wr_cnt; dn0 = done_cnt;
    start_frame();
    wait_done("t5");
    check("t5_writes", 32'(wr_cnt - wr0), 32'd6);
    check("t5_err", 32'(bus.frameErr), 32'd0);
    check("t5_sb_empty", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);

    // frameStart while busy and coincident with frameDone
    m_base = 8'h60; m_idx = 0;
    push_frame(6, 8'h60);
    wr0 = wr_cnt; dn0 = done_cnt;
    start_frame();
    n = 0;
    while (wr_cnt - wr0 < 2 && n < 300) begin @(negedge clk); n++; end
    check("t6_mid_frame", 32'(wr_cnt - wr0), 32'd2);
    start_frame();
    check("t6_busy_kept", 32'(bus.busy), 32'd1);
    wait_done("t6");
    start_frame();
    check("t6_start_on_done_ignored", 32'(bus.busy), 32'd0);
    repeat (20) @(negedge clk);
    check("t6_still_idle", 32'(bus.busy), 32'd0);
    check("t6_writes", 32'(wr_cnt - wr0), 32'd6);
    check("t6_dones", 32'(done_cnt - dn0), 32'd1);
    check("t6_sb_empty", 32'(sb.size()), 32'd0);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
